// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execute-stage ALU with registered result and flags.
// Single-cycle ops finish in one clock; MUL and optional iterative shifts run in BUSY.
module alu_multicycle #(
   parameter int WIDTH      = 16,
   parameter int ITER_SHIFT = 0,
   parameter int LHI_SHIFT  = WIDTH / 2,
   localparam int SHAMT_W   = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_op,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [SHAMT_W-1:0] in_shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic               out_zero,
   output logic               out_ovf,
   output logic               busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_TCP = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SRA = 4'd7;
   localparam logic [3:0] OP_LHI = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_SLT = 4'd10;

   logic [1:0]         state;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] cnt;

   logic               accept;
   logic               go_busy;
   logic               is_shift;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   tcp;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic [WIDTH-1:0]   mul_next;
   logic [WIDTH-1:0]   shift_next;
   logic [WIDTH-1:0]   iter_res;

   assign in_ready  = (state == S_IDLE) |
                      ((state == S_DONE) & out_ready);
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_BUSY);
   assign accept    = in_valid & in_ready;

   assign is_shift = (in_op == OP_SHL) | (in_op == OP_SRA);
   assign go_busy  = (in_op == OP_MUL) |
                     ((ITER_SHIFT != 0) & is_shift &
                      (in_shamt != '0));

   assign sum  = in_a + in_b;
   assign diff = in_a - in_b;
   assign tcp  = ~in_a + 1'b1;

   always_comb begin
      alu_res = in_a;
      alu_ovf = 1'b0;
      unique case (in_op)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) &
                      (sum[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) &
                      (diff[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_AND: alu_res = in_a & in_b;
         OP_OR:  alu_res = in_a | in_b;
         OP_NOT: alu_res = ~in_a;
         OP_TCP: begin
            alu_res = tcp;
            alu_ovf = (in_a == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_SHL: alu_res = in_a << in_shamt;
         OP_SRA: alu_res = $signed(in_a) >>> in_shamt;
         OP_LHI: alu_res = in_b << LHI_SHIFT;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                            ($signed(in_a) < $signed(in_b))};
         default: alu_res = in_a;
      endcase
   end

   // a_q doubles as multiplicand (MUL) or the value being shifted
   assign mul_next   = acc + (b_q[0] ? a_q : '0);
   assign shift_next = (op_q == OP_SHL) ?
                       {a_q[WIDTH-2:0], 1'b0} :
                       {a_q[WIDTH-1], a_q[WIDTH-1:1]};
   assign iter_res   = (op_q == OP_MUL) ? mul_next : shift_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc        <= '0;
         cnt        <= '0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_ovf    <= 1'b0;
      end else if (accept) begin
         op_q <= in_op;
         a_q  <= in_a;
         b_q  <= in_b;
         acc  <= '0;
         if (go_busy) begin
            state <= S_BUSY;
            cnt   <= (in_op == OP_MUL) ? SHAMT_W'(WIDTH-1)
                                       : in_shamt - 1'b1;
         end else begin
            state      <= S_DONE;
            out_result <= alu_res;
            out_zero   <= (alu_res == '0);
            out_ovf    <= alu_ovf;
         end
      end else begin
         unique case (state)
            S_IDLE: ;
            S_BUSY: begin
               acc <= mul_next;
               a_q <= (op_q == OP_MUL) ? (a_q << 1) : shift_next;
               b_q <= b_q >> 1;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state      <= S_DONE;
                  out_result <= iter_res;
                  out_zero   <= (iter_res == '0);
                  out_ovf    <= 1'b0;
               end
            end
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed checks of alu_multicycle at WIDTH=16,
// one instance with barrel shifts and one with iterative shifts.
module tb_alu_multicycle;

   localparam logic [3:0] ADD = 4'd0;
   localparam logic [3:0] SUB = 4'd1;
   localparam logic [3:0] AND = 4'd2;
   localparam logic [3:0] OR  = 4'd3;
   localparam logic [3:0] NOT = 4'd4;
   localparam logic [3:0] TCP = 4'd5;
   localparam logic [3:0] SHL = 4'd6;
   localparam logic [3:0] SRA = 4'd7;
   localparam logic [3:0] LHI = 4'd8;
   localparam logic [3:0] MUL = 4'd9;
   localparam logic [3:0] SLT = 4'd10;

   logic        clk = 1'b0;
   logic        reset;
   logic        v0, v1;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic [3:0]  sh;
   logic        ordy;

   logic        ir0, ov0, z0, f0, bz0;
   logic [15:0] r0;
   logic        ir1, ov1, z1, f1, bz1;
   logic [15:0] r1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(16), .ITER_SHIFT(0)) dut0 (
      .clk(clk), .reset(reset),
      .in_valid(v0), .in_ready(ir0),
      .in_op(op), .in_a(a), .in_b(b), .in_shamt(sh),
      .out_valid(ov0), .out_ready(ordy),
      .out_result(r0), .out_zero(z0), .out_ovf(f0),
      .busy(bz0)
   );

   alu_multicycle #(.WIDTH(16), .ITER_SHIFT(1)) dut1 (
      .clk(clk), .reset(reset),
      .in_valid(v1), .in_ready(ir1),
      .in_op(op), .in_a(a), .in_b(b), .in_shamt(sh),
      .out_valid(ov1), .out_ready(ordy),
      .out_result(r1), .out_zero(z1), .out_ovf(f1),
      .busy(bz1)
   );

   task automatic issue(input int which, input logic [3:0] o,
                        input logic [15:0] xa, input logic [15:0] xb,
                        input logic [3:0] xs);
      op = o; a = xa; b = xb; sh = xs;
      if (which == 0) v0 = 1'b1; else v1 = 1'b1;
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
   endtask

   // e = extra edges after the accept edge until out_valid shows
   task automatic wait_done(input int which, output int e);
      e = 0;
      while (((which == 0) ? ov0 : ov1) !== 1'b1 && e < 100) begin
         @(posedge clk); #1;
         e++;
      end
   endtask

   task automatic consume();
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b/%b exp=0/0", ov0, ov1);
      end
      checks++;
      if (r0 !== 16'h0 || z0 !== 1'b0 || f0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_out got=%h z=%b o=%b exp=0000 0 0", r0, z0, f0);
      end
      checks++;
      if (ir0 !== 1'b1 || bz0 !== 1'b0 || ir1 !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b busy=%b exp=1 0", ir0, bz0);
      end
   endtask

   task automatic test_add();
      int e;
      issue(0, ADD, 16'h7FFF, 16'h0001, 4'd0);
      wait_done(0, e);
      checks++;
      if (e + 1 !== 1) begin
         failures++;
         $display("FAIL add_latency got=%0d exp=1", e + 1);
      end
      checks++;
      if (r0 !== 16'h8000 || f0 !== 1'b1 || z0 !== 1'b0) begin
         failures++;
         $display("FAIL add_result got=%h o=%b z=%b exp=8000 1 0", r0, f0, z0);
      end
      consume();
      checks++;
      if (ov0 !== 1'b0) begin
         failures++;
         $display("FAIL add_consume got=%b exp=0", ov0);
      end
   endtask

   task automatic test_mul();
      int e;
      issue(0, MUL, 16'h0012, 16'h0034, 4'd0);
      a = 16'hFFFF; b = 16'hFFFF;
      e = 0;
      while (ov0 !== 1'b1 && e < 100) begin
         checks++;
         if (ir0 !== 1'b0 || bz0 !== 1'b1) begin
            failures++;
            $display("FAIL mul_busy cyc=%0d ready=%b busy=%b exp=0 1", e, ir0, bz0);
         end
         @(posedge clk); #1;
         e++;
      end
      checks++;
      if (e + 1 !== 17) begin
         failures++;
         $display("FAIL mul_latency got=%0d exp=17", e + 1);
      end
      checks++;
      if (r0 !== 16'h03A8 || z0 !== 1'b0 || f0 !== 1'b0) begin
         failures++;
         $display("FAIL mul_result got=%h z=%b o=%b exp=03a8 0 0", r0, z0, f0);
      end
      consume();
      issue(0, MUL, 16'hFFFF, 16'h0003, 4'd0);
      wait_done(0, e);
      checks++;
      if (r0 !== 16'hFFFD) begin
         failures++;
         $display("FAIL mul_signed got=%h exp=fffd", r0);
      end
      consume();
   endtask

   task automatic test_shift();
      int e;
      issue(0, SRA, 16'h8000, 16'h0, 4'd3);
      wait_done(0, e);
      checks++;
      if (e + 1 !== 1 || r0 !== 16'hF000) begin
         failures++;
         $display("FAIL sra_barrel got=%h lat=%0d exp=f000 lat=1", r0, e + 1);
      end
      consume();
      issue(1, SRA, 16'h8000, 16'h0, 4'd3);
      a = 16'h1234; sh = 4'd7;
      wait_done(1, e);
      checks++;
      if (e + 1 !== 4 || r1 !== 16'hF000 || f1 !== 1'b0) begin
         failures++;
         $display("FAIL sra_iter got=%h lat=%0d exp=f000 lat=4", r1, e + 1);
      end
      consume();
      issue(1, SHL, 16'h0003, 16'h0, 4'd4);
      wait_done(1, e);
      checks++;
      if (e + 1 !== 5 || r1 !== 16'h0030) begin
         failures++;
         $display("FAIL shl_iter got=%h lat=%0d exp=0030 lat=5", r1, e + 1);
      end
      consume();
      issue(1, SRA, 16'h8001, 16'h0, 4'd0);
      wait_done(1, e);
      checks++;
      if (e + 1 !== 1 || r1 !== 16'h8001) begin
         failures++;
         $display("FAIL sra_zero got=%h lat=%0d exp=8001 lat=1", r1, e + 1);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      int e;
      ordy = 1'b0;
      issue(0, SUB, 16'd5, 16'd5, 4'd0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (ov0 !== 1'b1 || r0 !== 16'h0 || z0 !== 1'b1 || ir0 !== 1'b0) begin
            failures++;
            $display("FAIL hold cyc=%0d v=%b r=%h z=%b rdy=%b exp=1 0000 1 0", i, ov0, r0, z0, ir0);
         end
         @(posedge clk); #1;
      end
      op = ADD; a = 16'd2; b = 16'd3; v0 = 1'b1; ordy = 1'b1;
      #1;
      checks++;
      if (ir0 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready got=%b exp=1", ir0);
      end
      @(posedge clk); #1;
      v0 = 1'b0; ordy = 1'b0;
      checks++;
      if (ov0 !== 1'b1 || r0 !== 16'd5 || z0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_result v=%b got=%h z=%b exp=1 0005 0", ov0, r0, z0);
      end
      consume();
      wait_done(0, e);
      checks++;
      if (e !== 100) begin
         failures++;
         $display("FAIL b2b_extra got=%0d exp=100", e);
      end
   endtask

   task automatic test_reset_mul();
      int e;
      issue(0, MUL, 16'h0012, 16'h0034, 4'd0);
      repeat (7) begin
         @(posedge clk); #1;
      end
      checks++;
      if (bz0 !== 1'b1) begin
         failures++;
         $display("FAIL rmul_busy got=%b exp=1", bz0);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ov0 !== 1'b0 || r0 !== 16'h0 || bz0 !== 1'b0 || ir0 !== 1'b1) begin
         failures++;
         $display("FAIL rmul_abort v=%b r=%h busy=%b rdy=%b exp=0 0000 0 1", ov0, r0, bz0, ir0);
      end
      #2 reset = 1'b0;
      @(posedge clk); #1;
      issue(0, SLT, 16'hFFFF, 16'h0001, 4'd0);
      wait_done(0, e);
      checks++;
      if (e + 1 !== 1 || r0 !== 16'h0001 || z0 !== 1'b0) begin
         failures++;
         $display("FAIL rmul_slt got=%h lat=%0d exp=0001 lat=1", r0, e + 1);
      end
      consume();
   endtask

   localparam int NV = 10;
   localparam logic [3:0]  T_OP [NV] = '{TCP, LHI, 4'd13, SUB, AND,
                                         OR, NOT, ADD, SLT, SHL};
   localparam logic [15:0] T_A  [NV] = '{16'h8000, 16'h1234, 16'h1234,
                                         16'h8000, 16'hF0F0, 16'h00F0,
                                         16'h00FF, 16'hFFFF, 16'h0001,
                                         16'h0001};
   localparam logic [15:0] T_B  [NV] = '{16'h0000, 16'h00AB, 16'h5555,
                                         16'h0001, 16'hFF00, 16'h0F00,
                                         16'h0000, 16'h0001, 16'hFFFF,
                                         16'h0000};
   localparam logic [3:0]  T_SH [NV] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                                         4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
   localparam logic [15:0] T_R  [NV] = '{16'h8000, 16'hAB00, 16'h1234,
                                         16'h7FFF, 16'hF000, 16'h0FF0,
                                         16'hFF00, 16'h0000, 16'h0000,
                                         16'h8000};
   localparam logic        T_O  [NV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic test_ops();
      int e;
      for (int i = 0; i < NV; i++) begin
         issue(0, T_OP[i], T_A[i], T_B[i], T_SH[i]);
         wait_done(0, e);
         checks++;
         if (r0 !== T_R[i] || f0 !== T_O[i] ||
             z0 !== (T_R[i] == 16'h0)) begin
            failures++;
            $display("FAIL op_vec%0d op=%0d got=%h o=%b z=%b exp=%h o=%b",
                     i, T_OP[i], r0, f0, z0, T_R[i], T_O[i]);
         end
         consume();
      end
   endtask

   initial begin
      reset = 1'b1;
      v0 = 1'b0; v1 = 1'b0; ordy = 1'b0;
      op = 4'd0; a = '0; b = '0; sh = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      test_add();
      test_mul();
      test_shift();
      test_back_to_back();
      test_reset_mul();
      test_ops();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
